// File: rtl/comparador_izq_der_pkg.sv
// Shared types for the serial left-to-right magnitude comparator.
package comparador_izq_der_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

endpackage

// File: rtl/comparador_bit.sv
// Combinational one-bit magnitude cell: flags a<b and a>b for a single bit pair.
module comparador_bit (
  input  logic a,
  input  logic b,
  output logic lt,
  output logic gt
);

  assign lt = ~a & b;
  assign gt = a & ~b;

endmodule

// File: rtl/comparador_izq_der.sv
// Serial MSB-first magnitude comparator; z = (A <= B), eq = (A == B), start/done handshake.
module comparador_izq_der
  import comparador_izq_der_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] wordA,
  input  logic [WIDTH-1:0] wordB,
  output logic             busy,
  output logic             done,
  output logic             z,
  output logic             eq
);

  localparam int unsigned IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(WIDTH - 1);

  state_t           state, state_d;
  logic [WIDTH-1:0] reg_a, reg_a_d;
  logic [WIDTH-1:0] reg_b, reg_b_d;
  logic [IDX_W-1:0] idx, idx_d;
  logic             busy_d, done_d, z_d, eq_d;
  logic             bit_lt, bit_gt;

  // Single cell looks at the currently selected bit pair
  comparador_bit u_bit (
    .a  (reg_a[idx]),
    .b  (reg_b[idx]),
    .lt (bit_lt),
    .gt (bit_gt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      reg_a <= '0;
      reg_b <= '0;
      idx   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      z     <= 1'b0;
      eq    <= 1'b0;
    end else begin
      state <= state_d;
      reg_a <= reg_a_d;
      reg_b <= reg_b_d;
      idx   <= idx_d;
      busy  <= busy_d;
      done  <= done_d;
      z     <= z_d;
      eq    <= eq_d;
    end
  end

  // Next-state and output-register values; done defaults low so it pulses for one cycle
  always_comb begin
    state_d = state;
    reg_a_d = reg_a;
    reg_b_d = reg_b;
    idx_d   = idx;
    busy_d  = busy;
    done_d  = 1'b0;
    z_d     = z;
    eq_d    = eq;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          reg_a_d = wordA;
          reg_b_d = wordB;
          idx_d   = IDX_MSB;
          busy_d  = 1'b1;
          z_d     = 1'b0;
          eq_d    = 1'b0;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (bit_lt || bit_gt || (idx == '0)) begin
          // First difference decides; reaching bit 0 with no difference means equal
          z_d     = ~bit_gt;
          eq_d    = ~bit_lt & ~bit_gt;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          idx_d = idx - IDX_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_comparador_izq_der.sv
// Scoreboard bench for comparador_izq_der: driver queues expected results, monitor checks each done.
module tb_comparador_izq_der;

  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] word_a, word_b;
  logic             busy, done, z, eq;

  typedef struct {
    logic  z;
    logic  eq;
    int    lat;
    int    t0;
    string name;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  comparador_izq_der #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .wordA (word_a),
    .wordB (word_b),
    .busy  (busy),
    .done  (done),
    .z     (z),
    .eq    (eq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Expectation for a start that the next rising edge will accept
  task automatic push_exp(input logic ez, input logic eeq, input int lat, input int t0,
                          input string name);
    exp_t e;
    e.z = ez; e.eq = eeq; e.lat = lat; e.t0 = t0; e.name = name;
    sb.push_back(e);
  endtask

  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic ez, input logic eeq, input int lat, input string name);
    @(negedge clk);
    word_a = a;
    word_b = b;
    start  = 1'b1;
    push_exp(ez, eeq, lat, cyc + 1, name);
    @(negedge clk);
    start = 1'b0;
    check({name, "_busy"}, int'(busy), 1);
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: %0d results still pending, expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (!reset && done) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: done=1 with no pending request (t=%0t)", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, "_z"}, int'(z), int'(e.z));
        check({e.name, "_eq"}, int'(eq), int'(e.eq));
        check({e.name, "_lat"}, cyc - e.t0, e.lat);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    word_a = '0;
    word_b = '0;
    #1;
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_z", int'(z), 0);
    check("reset_eq", int'(eq), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // 1. equal zeros: full scan
    issue(8'h00, 8'h00, 1'b1, 1'b1, 8, "t1_eq00");
    wait_idle("t1");

    // 2. differs at bit 6, A > B
    issue(8'b11100111, 8'b10000001, 1'b0, 1'b0, 2, "t2_bit6");
    wait_idle("t2");

    // 3. differs at bit 1, then at bit 0
    issue(8'h0A, 8'h09, 1'b0, 1'b0, 7, "t3_bit1");
    wait_idle("t3a");
    issue(8'h00, 8'h01, 1'b1, 1'b0, 8, "t3_bit0");
    wait_idle("t3b");

    // 4. one-cycle result, start held through done for back-to-back op
    @(negedge clk);
    word_a = 8'h80;
    word_b = 8'h00;
    start  = 1'b1;
    push_exp(1'b0, 1'b0, 1, cyc + 1, "t4_msb");
    @(negedge clk);
    word_a = 8'h01;
    word_b = 8'h01;
    push_exp(1'b1, 1'b1, 8, cyc + 2, "t4_b2b");
    @(negedge clk);
    check("t4_done_cycle_busy", int'(busy), 0);
    @(negedge clk);
    start = 1'b0;
    check("t4_b2b_busy", int'(busy), 1);
    wait_idle("t4");

    // 5. start and operand changes while busy are ignored
    issue(8'h12, 8'h13, 1'b1, 1'b0, 8, "t5_orig");
    @(negedge clk);
    word_a = 8'hFF;
    word_b = 8'h00;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    word_a = 8'h00;
    word_b = 8'hFF;
    wait_idle("t5");
    repeat (4) @(negedge clk);

    // 6. asynchronous reset mid-scan aborts without done
    issue(8'hFF, 8'hFF, 1'b1, 1'b1, 8, "t6_abort");
    repeat (2) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    sb.delete();
    check("t6_rst_busy", int'(busy), 0);
    check("t6_rst_done", int'(done), 0);
    check("t6_rst_z", int'(z), 0);
    check("t6_rst_eq", int'(eq), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    issue(8'h55, 8'h54, 1'b0, 1'b0, 8, "t6_fresh");
    wait_idle("t6");
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
